reduce_gate_unit: RTL and testbench

- Parametrised, pipelined N-input logic reduction unit; successor to the fixed 3-input combinational AND gate.
- Each accepted input vector is reduced with a runtime-selected operation: AND/OR/XOR/NAND/NOR/XNOR/majority.
- Result, popcount and error flag are delivered through a valid/ready stream with a 2-entry skid buffer.
- A saturating counter tracks delivered 1-results.
- Sits as a reusable gate primitive between stimulus/streaming logic and downstream consumers.

---
 rtl/gate_pkg.sv | 62 ++++++
 rtl/skid_buffer.sv | 77 +++++++
 rtl/reduce_gate_unit.sv | 88 ++++++++
 tb/tb_reduce_gate_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the reduce_gate_unit slice.
//   OP_*          operation select codes (3 bits wide, OP_W)
//   skid_state_t  occupancy of the 2-entry output slice
//   popcount()    number of set bits in a zero-padded 64-bit vector
//   reduce()      {err, result} for one vector, width and op
package gate_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_N = 64;
  localparam int POP_W = 7;  // enough to count up to MAX_N ones

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_MAJ  = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_N-1:0] d);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) c = c + POP_W'(d[i]);
    return c;
  endfunction

  // Unused upper bits of d must be zero; n is the real input width, so
  // "all ones" means popcount == n rather than a 64-bit AND.
  function automatic logic [1:0] reduce(input logic [MAX_N-1:0] d,
                                        input logic [POP_W-1:0] n,
                                        input logic [OP_W-1:0]  op);
    logic [POP_W-1:0] ones;
    logic             all_set;
    logic             any_set;
    logic             res;
    logic             err;
    ones    = popcount(d);
    all_set = (ones == n);
    any_set = (ones != '0);
    res     = 1'b0;
    err     = 1'b0;
    case (op)
      OP_AND:  res = all_set;
      OP_OR:   res = any_set;
      OP_XOR:  res = ones[0];
      OP_NAND: res = !all_set;
      OP_NOR:  res = !any_set;
      OP_XNOR: res = !ones[0];
      OP_MAJ:  res = (ones > (n >> 1));  // ties fall to 0
      default: err = 1'b1;               // OP_RSVD
    endcase
    return {err, res};
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready register slice.
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready/in_data    upstream stream (in_ready registered)
//   out_ready/out_data           downstream stream
//   state                  occupancy (skid_state_t); out_valid = state != EMPTY
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; a producer holding valid keeps its data stable until it transfers,
// and out_data never changes while a result is offered and not yet taken.
module skid_buffer
  import gate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   state
);

  skid_state_t  st;
  logic [W-1:0] out_reg;
  logic [W-1:0] skid_reg;
  logic         accept;
  logic         hs;

  assign accept   = in_valid & in_ready;
  assign hs       = (st != SKID_EMPTY) & out_ready;
  assign out_data = out_reg;
  assign state    = st;

  // in_ready is registered: it is set for the state being entered, so it is
  // low in FULL and low during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= SKID_EMPTY;
      in_ready <= 1'b0;
      out_reg  <= '0;
      skid_reg <= '0;
    end else begin
      in_ready <= 1'b1;
      case (st)
        SKID_EMPTY: begin
          if (accept) begin
            out_reg <= in_data;
            st      <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && hs) begin
            out_reg <= in_data;
          end else if (accept) begin
            skid_reg <= in_data;
            st       <= SKID_FULL;
            in_ready <= 1'b0;
          end else if (hs) begin
            st <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (hs) begin
            out_reg  <= skid_reg;
            skid_reg <= '0;
            st       <= SKID_ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: st <= SKID_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/reduce_gate_unit.sv
// Pipelined N-input logic reduction with a streamed result.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready registered)
//   in_data[N_IN]        bits to reduce; in_op[3] selects the operation
//   out_valid/out_ready  result handshake
//   out_data             reduction result
//   out_ones             popcount of the originating in_data
//   out_err              originating in_op was reserved
//   cnt_clr              synchronous clear of one_cnt (wins over increment)
//   one_cnt[CNT_W]       saturating count of delivered 1-results
module reduce_gate_unit
  import gate_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_data,
  input  logic [OP_W-1:0]            in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_data,
  output logic [$clog2(N_IN+1)-1:0]  out_ones,
  output logic                       out_err,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           one_cnt
);

  localparam int OW = $clog2(N_IN + 1);
  localparam int W  = OW + 2;

  generate
    if (N_IN < 2 || N_IN > MAX_N) begin : g_bad_n
      $error("reduce_gate_unit: N_IN must be in 2..64");
    end
  endgenerate

  logic [MAX_N-1:0] data_ext;
  logic [OP_W-1:0]  op_m;
  logic [1:0]       red;
  logic [W-1:0]     pkt;
  logic [W-1:0]     slot;
  logic [1:0]       skid_state;
  logic             hs_out;

  // Inputs are masked while in_valid is low so X on an idle bus never
  // reaches the reduction logic.
  always_comb begin
    data_ext = '0;
    op_m     = OP_AND;
    if (in_valid) begin
      data_ext[N_IN-1:0] = in_data;
      op_m               = in_op;
    end
  end

  assign red = reduce(data_ext, POP_W'(N_IN), op_m);
  assign pkt = {red[1], OW'(popcount(data_ext)), red[0]};

  skid_buffer #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pkt),
    .out_ready (out_ready),
    .out_data  (slot),
    .state     (skid_state)
  );

  assign out_valid = (skid_state != SKID_EMPTY);
  assign {out_err, out_ones, out_data} = slot;
  assign hs_out = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      one_cnt <= '0;
    end else if (cnt_clr) begin
      one_cnt <= '0;
    end else if (hs_out && out_data && (one_cnt != '1)) begin
      one_cnt <= one_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reduce_gate_unit.sv
module tb_reduce_gate_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_op = 3'd0;
  logic       out_ready = 1'b0;
  logic       cnt_clr = 1'b0;

  // main instance: N_IN=3, CNT_W=16
  logic        in_ready, out_valid, out_data, out_err;
  logic [2:0]  in_data = 3'd0;
  logic [1:0]  out_ones;
  logic [15:0] one_cnt;

  // wide instance: N_IN=8, CNT_W=2, shares valid/ready/op/clr
  logic       b_in_ready, b_out_valid, b_out_data, b_out_err;
  logic [7:0] b_data = 8'd0;
  logic [3:0] b_out_ones;
  logic [1:0] b_one_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [8:0] exp_q[$];   // {err, ones[6:0], result}
  logic [8:0] exp8_q[$];
  int         m_cnt  = 0;
  int         m8_cnt = 0;
  bit         m_ready = 0;

  always #5 clk = ~clk;

  reduce_gate_unit #(.N_IN(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ones(out_ones),
    .out_err(out_err), .cnt_clr(cnt_clr), .one_cnt(one_cnt)
  );

  reduce_gate_unit #(.N_IN(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(b_data), .in_op(in_op), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_ones(b_out_ones),
    .out_err(b_out_err), .cnt_clr(cnt_clr), .one_cnt(b_one_cnt)
  );

  // Reference: count the ones, then apply the operation's definition.
  function automatic logic [8:0] ref_reduce(input logic [63:0] d, input int n,
                                            input int op);
    int  ones;
    bit  res;
    bit  err;
    ones = 0;
    for (int i = 0; i < n; i++) if (d[i]) ones++;
    res = 0;
    err = 0;
    case (op)
      0: res = (ones == n);
      1: res = (ones > 0);
      2: res = (ones % 2 == 1);
      3: res = (ones != n);
      4: res = (ones == 0);
      5: res = (ones % 2 == 0);
      6: res = (ones > n / 2);
      default: err = 1;
    endcase
    return {err, 7'(ones), res};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, cross one rising edge, update the model.
  // Called with inputs already set after a falling edge; returns at the
  // next falling edge.
  task automatic tick();
    bit         acc, hs, clr;
    logic [8:0] e, e8;
    check("in_ready", 32'(in_ready), 32'(m_ready));
    check("b_in_ready", 32'(b_in_ready), 32'(m_ready));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("b_out_valid", 32'(b_out_valid), 32'(exp8_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_data", 32'(out_data), 32'(exp_q[0][0]));
      check("out_ones", 32'(out_ones), 32'(exp_q[0][7:1]));
      check("out_err", 32'(out_err), 32'(exp_q[0][8]));
      check("b_out_data", 32'(b_out_data), 32'(exp8_q[0][0]));
      check("b_out_ones", 32'(b_out_ones), 32'(exp8_q[0][7:1]));
      check("b_out_err", 32'(b_out_err), 32'(exp8_q[0][8]));
    end
    check("one_cnt", 32'(one_cnt), 32'(m_cnt));
    check("b_one_cnt", 32'(b_one_cnt), 32'(m8_cnt));
    acc = rst_n && in_valid && m_ready;
    hs  = rst_n && out_ready && (exp_q.size() != 0);
    clr = cnt_clr;
    e   = ref_reduce(64'(in_data), 3, int'(in_op));
    e8  = ref_reduce(64'(b_data), 8, int'(in_op));
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      exp8_q.delete();
      m_cnt   = 0;
      m8_cnt  = 0;
      m_ready = 0;
    end else begin
      logic [8:0] h, h8;
      h  = '0;
      h8 = '0;
      if (hs) begin
        h  = exp_q.pop_front();
        h8 = exp8_q.pop_front();
      end
      if (clr) begin
        m_cnt  = 0;
        m8_cnt = 0;
      end else begin
        if (hs && h[0] && m_cnt < 65535) m_cnt++;
        if (hs && h8[0] && m8_cnt < 3) m8_cnt++;
      end
      if (acc) begin
        exp_q.push_back(e);
        exp8_q.push_back(e8);
      end
      m_ready = (exp_q.size() < 2);
    end
    @(negedge clk);
  endtask

  // Hold in_valid until the model says the vector was taken.
  task automatic push(input logic [2:0] d, input logic [7:0] d8,
                      input logic [2:0] op);
    int budget;
    bit taken;
    in_valid = 1'b1;
    in_data  = d;
    b_data   = d8;
    in_op    = op;
    budget   = 20;
    taken    = 0;
    while (!taken && budget > 0) begin
      taken = m_ready;
      tick();
      budget--;
    end
    if (!taken) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    exp_q.delete();
    exp8_q.delete();
    m_cnt   = 0;
    m8_cnt  = 0;
    m_ready = 0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ones", 32'(out_ones), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_one_cnt", 32'(one_cnt), 32'd0);
    check("rst_b_one_cnt", 32'(b_one_cnt), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int         ex_op[4];
    logic [3:0] ex_res;
    logic [7:0] w_data[4];
    int         w_op[4];
    logic [3:0] w_res;
    int         w_ones[4];

    // reset
    do_reset(2);
    tick();

    // exhaustive sweep on the 3-input unit, one vector per clock
    out_ready = 1'b1;
    for (int op = 0; op < 7; op++) begin
      for (int v = 0; v < 8; v++) begin
        in_valid = 1'b1;
        in_op    = 3'(op);
        in_data  = 3'(v);
        b_data   = 8'($urandom);
        tick();
      end
    end
    in_valid = 1'b0;
    tick();

    // spot values for 3'b101: AND=0 OR=1 XOR=0 MAJ=1, two ones
    ex_op  = '{0, 1, 2, 6};
    ex_res = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 3'b101;
      in_op    = 3'(ex_op[k]);
      tick();
      check("ex101_data", 32'(out_data), 32'(ex_res[k]));
      check("ex101_ones", 32'(out_ones), 32'd2);
    end
    in_valid = 1'b0;
    tick();

    // backpressure: third vector waits until the slice drains
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 3'b111; b_data = 8'($urandom); in_op = 3'd0; tick();
    in_data = 3'b000; b_data = 8'($urandom); in_op = 3'd4; tick();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    in_data = 3'b011; b_data = 8'($urandom); in_op = 3'd2; tick();
    out_ready = 1'b1;
    push(3'b011, b_data, 3'd2);
    drain();

    // reserved op
    push(3'b111, 8'hFF, 3'd7);
    check("rsvd_err", 32'(out_err), 32'd1);
    check("rsvd_data", 32'(out_data), 32'd0);
    check("rsvd_ones", 32'(out_ones), 32'd3);
    tick();

    // counter: clear, five 1-results, saturation on the 2-bit counter
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) push(3'b111, 8'hFF, 3'd0);
    drain();
    check("cnt_five", 32'(one_cnt), 32'd5);
    check("cnt_sat", 32'(b_one_cnt), 32'd3);
    // clear together with a 1-result handshake
    push(3'b111, 8'hFF, 3'd0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr_hs", 32'(one_cnt), 32'd0);
    tick();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_data   = 3'($urandom);
      b_data    = 8'($urandom);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      tick();
    end
    cnt_clr = 1'b0;
    drain();

    // 8-input unit: tie and odd-majority cases
    w_data = '{8'hF0, 8'hF0, 8'hF8, 8'hF8};
    w_op   = '{6, 2, 6, 2};
    w_res  = 4'b1100;
    w_ones = '{4, 4, 5, 5};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(3'($urandom), w_data[k], 3'(w_op[k]));
      check("n8_data", 32'(b_out_data), 32'(w_res[k]));
      check("n8_ones", 32'(b_out_ones), 32'(w_ones[k]));
    end
    tick();

    // reset with two results pending
    push(3'b111, 8'hFF, 3'd0);
    out_ready = 1'b0;
    push(3'b111, 8'hFF, 3'd1);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    do_reset(1);
    tick();
    out_ready = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
